matmul_scheduler: RTL and testbench



---
 rtl/matmul_pkg.sv | 46 ++++
 rtl/loop_walker.sv | 70 +++++++
 rtl/matmul_scheduler.sv | 237 +++++++++++++++++++++++
 tb/tb_matmul_scheduler.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types and constants for the matmul_scheduler block.
//   sched_state_t : scheduler FSM states
//   dims_t        : {m, k, n} job dimensions
//   calc_dim_w / calc_addr_w : width helpers
//   DROP_W        : width of the saturating drop counter
package matmul_pkg;

  localparam int MAX_DIM    = 32;
  localparam int ELEM_W     = 8;
  localparam int CK_TIMEOUT = 1024;

  function automatic int calc_dim_w(input int max_dim);
    return $clog2(max_dim + 1);
  endfunction

  function automatic int calc_addr_w(input int max_dim);
    return $clog2(max_dim * max_dim);
  endfunction

  localparam int DIM_W  = calc_dim_w(MAX_DIM);
  localparam int ADDR_W = calc_addr_w(MAX_DIM);
  localparam int DROP_W = 16;
  localparam int TMO_W  = $clog2(CK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HDR      = 3'd1,
    LOAD_A   = 3'd2,
    LOAD_B   = 3'd3,
    WAIT_CK  = 3'd4,
    RUN      = 3'd5,
    DRAIN_RX = 3'd6
  } sched_state_t;

  typedef struct packed {
    logic [DIM_W-1:0] m;
    logic [DIM_W-1:0] k;
    logic [DIM_W-1:0] n;
  } dims_t;

  // A dimension is usable when it is non-zero and no larger than MAX_DIM.
  function automatic logic dim_ok(input logic [DIM_W-1:0] d);
    return (d != '0) && (d <= DIM_W'(MAX_DIM));
  endfunction

endpackage

// File: rtl/loop_walker.sv
// i/j/k loop nest walker for the matmul issue stream (k innermost).
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   clear             : hold all counters at zero (used outside RUN)
//   advance           : step one position (issue handshake)
//   m_dim/k_dim/n_dim : job dimensions
//   a_addr, b_addr    : i*K+k and k*N+j, generated without multipliers
//   first, last       : k==0 and k==K-1
//   final_step        : current position is (M-1, N-1, K-1)
module loop_walker
  import matmul_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              advance,
  input  logic [DIM_W-1:0]  m_dim,
  input  logic [DIM_W-1:0]  k_dim,
  input  logic [DIM_W-1:0]  n_dim,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  output logic              first,
  output logic              last,
  output logic              final_step
);

  logic [DIM_W-1:0]  i_cnt, j_cnt, k_cnt;
  logic [ADDR_W-1:0] row_base;  // i*K, start of the current A row
  logic              k_end, j_end, i_end;

  assign k_end      = (k_cnt == k_dim - DIM_W'(1));
  assign j_end      = (j_cnt == n_dim - DIM_W'(1));
  assign i_end      = (i_cnt == m_dim - DIM_W'(1));
  assign first      = (k_cnt == '0);
  assign last       = k_end;
  assign final_step = i_end & j_end & k_end;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      i_cnt    <= '0;
      j_cnt    <= '0;
      k_cnt    <= '0;
      row_base <= '0;
      a_addr   <= '0;
      b_addr   <= '0;
    end else if (advance) begin
      if (!k_end) begin
        k_cnt  <= k_cnt + DIM_W'(1);
        a_addr <= a_addr + ADDR_W'(1);
        b_addr <= b_addr + ADDR_W'(n_dim);
      end else begin
        k_cnt <= '0;
        if (!j_end) begin
          // Next column: same A row restarts, B restarts at column j+1.
          j_cnt  <= j_cnt + DIM_W'(1);
          a_addr <= row_base;
          b_addr <= ADDR_W'(j_cnt) + ADDR_W'(1);
        end else begin
          // Next row: A moves on by K, B back to column 0.
          j_cnt    <= '0;
          i_cnt    <= i_cnt + DIM_W'(1);
          row_base <= row_base + ADDR_W'(k_dim);
          a_addr   <= row_base + ADDR_W'(k_dim);
          b_addr   <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/matmul_scheduler.sv
// Per-frame matrix-multiply job sequencer: parses the {M,K,N} header,
// writes A then B into the operand buffers, waits for the checksum
// verdict and then issues the i/j/k read stream to the MAC datapath.
// Optional feature macro: SCHED_STATS_EN adds drop_count (saturating).
// Ports:
//   axiiv/axiid          : element stream, axiiv high for a whole frame
//   ck_done/ck_kill      : checksum verdict pulse and its "bad" qualifier
//   a_we/b_we, *_waddr   : operand buffer writes, wdata shared (1 cycle late)
//   iss_valid/iss_ready  : issue handshake; a_raddr, b_raddr, mac_first,
//                          mac_last are the payload
//   dims                 : {M,K,N} of the current job
//   busy, job_done       : not-idle flag, end-of-job pulse
// Handshake: an issue transfers on a cycle with iss_valid & iss_ready;
// while iss_valid is high without iss_ready the payload is held and
// iss_valid stays high.
module matmul_scheduler
  import matmul_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               axiiv,
  input  logic [ELEM_W-1:0]  axiid,
  input  logic               ck_done,
  input  logic               ck_kill,
  output logic               a_we,
  output logic               b_we,
  output logic [ADDR_W-1:0]  a_waddr,
  output logic [ADDR_W-1:0]  b_waddr,
  output logic [ELEM_W-1:0]  wdata,
  output logic               iss_valid,
  input  logic               iss_ready,
  output logic [ADDR_W-1:0]  a_raddr,
  output logic [ADDR_W-1:0]  b_raddr,
  output logic               mac_first,
  output logic               mac_last,
  output logic [3*DIM_W-1:0] dims,
  output logic               busy,
  output logic               job_done
`ifdef SCHED_STATS_EN
  ,
  output logic [DROP_W-1:0]  drop_count
`endif
);

  sched_state_t      state, state_nxt;
  dims_t             dims_q;
  logic              axiiv_q, rx_rise, hdr_sel;
  logic [DIM_W-1:0]  elem_dim, wr_row, wr_col, wr_rows, wr_cols;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_last;
  logic              ck_pend, ck_pend_kill, ck_seen, ck_bad;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              tmo_hit;
  logic              fsm_drop, rx_drop, advance;
  logic              walk_first, walk_last, walk_final;
  logic [ADDR_W-1:0] walk_a, walk_b;

  assign rx_rise  = axiiv & ~axiiv_q;
  assign elem_dim = axiid[DIM_W-1:0];
  // A verdict latched at the end of LOAD_B counts as if it arrived now.
  assign ck_seen  = ck_done | ck_pend;
  assign ck_bad   = ck_done ? ck_kill : ck_pend_kill;
  assign tmo_hit  = (tmo_cnt == TMO_W'(CK_TIMEOUT - 1));
  // A new frame cannot be buffered while a job is pending or running.
  assign rx_drop  = rx_rise & ((state == WAIT_CK) | (state == RUN));

  assign iss_valid = (state == RUN);
  assign advance   = iss_valid & iss_ready;
  assign a_raddr   = walk_a;
  assign b_raddr   = walk_b;
  assign mac_first = iss_valid & walk_first;
  assign mac_last  = iss_valid & walk_last;
  assign dims      = dims_q;
  assign busy      = (state != IDLE);

  // Write loop bounds: A is M rows of K, B is K rows of N.
  always_comb begin
    wr_rows = dims_q.m;
    wr_cols = dims_q.k;
    if (state == LOAD_B) begin
      wr_rows = dims_q.k;
      wr_cols = dims_q.n;
    end
  end
  assign wr_last = (wr_row == wr_rows - DIM_W'(1)) && (wr_col == wr_cols - DIM_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fsm_drop  = 1'b0;
    case (state)
      IDLE:     if (rx_rise) state_nxt = HDR;
      HDR: begin
        if (!axiiv) begin
          state_nxt = IDLE;
          fsm_drop  = 1'b1;
        end else if (hdr_sel) begin
          if (dim_ok(dims_q.m) && dim_ok(dims_q.k) && dim_ok(elem_dim)) begin
            state_nxt = LOAD_A;
          end else begin
            state_nxt = DRAIN_RX;
            fsm_drop  = 1'b1;
          end
        end
      end
      LOAD_A, LOAD_B: begin
        if (!axiiv) begin
          state_nxt = IDLE;
          fsm_drop  = 1'b1;
        end else if (wr_last) begin
          state_nxt = (state == LOAD_A) ? LOAD_B : WAIT_CK;
        end
      end
      WAIT_CK: begin
        if (ck_seen) begin
          state_nxt = ck_bad ? IDLE : RUN;
          fsm_drop  = ck_bad;
        end else if (tmo_hit) begin
          state_nxt = IDLE;
          fsm_drop  = 1'b1;
        end
      end
      RUN:      if (advance && walk_final) state_nxt = IDLE;
      DRAIN_RX: if (!axiiv) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      axiiv_q      <= 1'b0;
      dims_q       <= '0;
      hdr_sel      <= 1'b0;
      wr_row       <= '0;
      wr_col       <= '0;
      wr_addr      <= '0;
      ck_pend      <= 1'b0;
      ck_pend_kill <= 1'b0;
      tmo_cnt      <= '0;
      a_we         <= 1'b0;
      b_we         <= 1'b0;
      a_waddr      <= '0;
      b_waddr      <= '0;
      wdata        <= '0;
      job_done     <= 1'b0;
    end else begin
      axiiv_q  <= axiiv;
      a_we     <= 1'b0;
      b_we     <= 1'b0;
      job_done <= (state == RUN) & advance & walk_final;
      tmo_cnt  <= (state == WAIT_CK) ? tmo_cnt + TMO_W'(1) : '0;
      case (state)
        IDLE: begin
          if (rx_rise) dims_q.m <= elem_dim;
          hdr_sel <= 1'b0;
        end
        HDR: begin
          if (axiiv) begin
            if (!hdr_sel) dims_q.k <= elem_dim;
            else          dims_q.n <= elem_dim;
            hdr_sel <= 1'b1;
          end
          wr_row       <= '0;
          wr_col       <= '0;
          wr_addr      <= '0;
          ck_pend      <= 1'b0;
          ck_pend_kill <= 1'b0;
        end
        LOAD_A, LOAD_B: begin
          if (axiiv) begin
            wdata <= axiid;
            if (state == LOAD_A) begin
              a_we    <= 1'b1;
              a_waddr <= wr_addr;
            end else begin
              b_we    <= 1'b1;
              b_waddr <= wr_addr;
            end
            if (wr_last) begin
              wr_row  <= '0;
              wr_col  <= '0;
              wr_addr <= '0;
            end else begin
              wr_addr <= wr_addr + ADDR_W'(1);
              if (wr_col == wr_cols - DIM_W'(1)) begin
                wr_col <= '0;
                wr_row <= wr_row + DIM_W'(1);
              end else begin
                wr_col <= wr_col + DIM_W'(1);
              end
            end
          end
          if (state == LOAD_B && ck_done) begin
            ck_pend      <= 1'b1;
            ck_pend_kill <= ck_kill;
          end
        end
        default: ;
      endcase
    end
  end

  loop_walker u_walker (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (state != RUN),
    .advance    (advance),
    .m_dim      (dims_q.m),
    .k_dim      (dims_q.k),
    .n_dim      (dims_q.n),
    .a_addr     (walk_a),
    .b_addr     (walk_b),
    .first      (walk_first),
    .last       (walk_last),
    .final_step (walk_final)
  );

`ifdef SCHED_STATS_EN
  logic [DROP_W:0] drop_sum;
  assign drop_sum = {1'b0, drop_count} + (DROP_W+1)'(fsm_drop) + (DROP_W+1)'(rx_drop);

  always_ff @(posedge clk) begin
    if (!rst_n)                drop_count <= '0;
    else if (drop_sum[DROP_W]) drop_count <= '1;
    else                       drop_count <= drop_sum[DROP_W-1:0];
  end
`else
  // Drop events still steer the FSM; without stats they are not counted.
  logic unused_drop;
  assign unused_drop = fsm_drop ^ rx_drop;
`endif

endmodule

// File: tb/tb_matmul_scheduler.sv
// Self-checking bench for matmul_scheduler: directed frames from the
// test plan plus randomized jobs, scored against a loop-nest model.
module tb_matmul_scheduler;
  import matmul_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              axiiv = 1'b0;
  logic [ELEM_W-1:0] axiid = '0;
  logic              ck_done = 1'b0, ck_kill = 1'b0, iss_ready = 1'b0;
  logic              a_we, b_we, iss_valid, mac_first, mac_last, busy, job_done;
  logic [ADDR_W-1:0] a_waddr, b_waddr, a_raddr, b_raddr;
  logic [ELEM_W-1:0] wdata;
  logic [3*DIM_W-1:0] dims;
`ifdef SCHED_STATS_EN
  logic [DROP_W-1:0] drop_count;
`endif

  matmul_scheduler dut (
    .clk(clk), .rst_n(rst_n), .axiiv(axiiv), .axiid(axiid),
    .ck_done(ck_done), .ck_kill(ck_kill),
    .a_we(a_we), .b_we(b_we), .a_waddr(a_waddr), .b_waddr(b_waddr), .wdata(wdata),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .a_raddr(a_raddr), .b_raddr(b_raddr),
    .mac_first(mac_first), .mac_last(mac_last), .dims(dims), .busy(busy), .job_done(job_done)
`ifdef SCHED_STATS_EN
    , .drop_count(drop_count)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_total = 0, n_bad = 0;
  int exp_drop = 0;
  logic [18:0] exp_w_q[$];   // {is_b, addr, data}
  logic [22:0] exp_i_q[$];   // {final, first, last, a, b}
  logic [21:0] obs_i_q[$];   // {first, last, a, b} as seen on handshakes
  logic [7:0]  frame_q[$];
  int ck_at = -1;
  logic ck_at_kill = 1'b0;
  int jm, jk, jn;
  int n_awr, n_bwr, n_done, cyc = 0, first_v_cyc = -1, done_cyc = -1;
  logic [3*DIM_W-1:0] dims_at_run;
  bit chk_en = 0, done_pend = 0, hold_pend = 0;
  logic [21:0] held;
  int ready_mode = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
    end
  endtask

  // ---------------- ready generator ----------------
  initial begin
    int ph = 0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: iss_ready = 1'b1;
        1: begin iss_ready = (ph == 0) || (ph == 3); ph = (ph + 1) % 4; end
        default: iss_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- compare process ----------------
  initial begin
    logic [21:0] cur;
    logic [22:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (chk_en) begin
        cur = {mac_first, mac_last, a_raddr, b_raddr};
        if (a_we || b_we) begin
          if (a_we) n_awr++;
          if (b_we) n_bwr++;
          check("wr_expected", 32'(exp_w_q.size() > 0), 1);
          if (exp_w_q.size() > 0)
            check("wr", {b_we, (b_we ? b_waddr : a_waddr), wdata}, exp_w_q.pop_front());
        end
        if (done_pend) begin
          check("job_done", job_done, 1);
          check("busy_at_done", busy, 0);
          n_done++;
          done_cyc = cyc;
          done_pend = 0;
        end else if (job_done) begin
          check("job_done_spurious", job_done, 0);
        end
        if (hold_pend) begin
          check("iss_hold_valid", iss_valid, 1);
          check("iss_hold_data", cur, held);
        end
        if (iss_valid && iss_ready) begin
          if (first_v_cyc < 0) begin first_v_cyc = cyc; dims_at_run = dims; end
          obs_i_q.push_back(cur);
          check("iss_expected", 32'(exp_i_q.size() > 0), 1);
          if (exp_i_q.size() > 0) begin
            e = exp_i_q.pop_front();
            check("iss", cur, e[21:0]);
            done_pend = e[22];
          end
        end
        hold_pend = iss_valid && !iss_ready;
        held = cur;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic zero_checks(input string tag);
    check({tag, "_we"}, {a_we, b_we}, 0);
    check({tag, "_wr"}, {a_waddr, b_waddr, wdata}, 0);
    check({tag, "_iss"}, {iss_valid, mac_first, mac_last, a_raddr, b_raddr}, 0);
    check({tag, "_dims"}, dims, 0);
    check({tag, "_busy_done"}, {busy, job_done}, 0);
`ifdef SCHED_STATS_EN
    check({tag, "_drop"}, drop_count, 0);
`endif
  endtask

  task automatic apply_reset(input string tag);
    chk_en = 0; rst_n = 0; axiiv = 0; ck_done = 0; ck_kill = 0;
    @(posedge clk); @(negedge clk);
    zero_checks(tag);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    exp_w_q.delete(); exp_i_q.delete();
    done_pend = 0; hold_pend = 0; exp_drop = 0;
    chk_en = 1;
  endtask

  task automatic clr_stats();
    n_awr = 0; n_bwr = 0; n_done = 0; obs_i_q.delete();
    first_v_cyc = -1; done_cyc = -1;
  endtask

  // Build a frame: header, the first n_pay payload elements, then extras.
  task automatic make_job(input int m, input int k, input int n, input int n_pay,
                          input int extra, input bit fixed);
    int mk, kn;
    logic [7:0] d;
    mk = m * k; kn = k * n;
    jm = m; jk = k; jn = n;
    frame_q.delete();
    frame_q.push_back(8'(m)); frame_q.push_back(8'(k)); frame_q.push_back(8'(n));
    for (int p = 0; p < mk + kn; p++) begin
      d = fixed ? 8'(p + 1) : 8'($urandom_range(0, 255));
      if (p < n_pay) begin
        frame_q.push_back(d);
        if (p < mk) exp_w_q.push_back({1'b0, 10'(p), d});
        else        exp_w_q.push_back({1'b1, 10'(p - mk), d});
      end
    end
    for (int x = 0; x < extra; x++) frame_q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic expect_issues();
    for (int i = 0; i < jm; i++)
      for (int j = 0; j < jn; j++)
        for (int kk = 0; kk < jk; kk++)
          exp_i_q.push_back({(i == jm-1) && (j == jn-1) && (kk == jk-1),
                             kk == 0, kk == jk-1, 10'(i*jk + kk), 10'(kk*jn + j)});
  endtask

  task automatic send_frame();
    for (int i = 0; i < frame_q.size(); i++) begin
      @(posedge clk); #1;
      axiiv = 1'b1; axiid = frame_q[i];
      ck_done = (i == ck_at); ck_kill = (i == ck_at) && ck_at_kill;
    end
    @(posedge clk); #1;
    axiiv = 1'b0; axiid = '0; ck_done = 1'b0; ck_kill = 1'b0;
    ck_at = -1;
  endtask

  task automatic verdict(input bit kill, input int delay);
    repeat (delay) begin @(posedge clk); #1; end
    ck_done = 1'b1; ck_kill = kill;
    @(posedge clk); #1;
    ck_done = 1'b0; ck_kill = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check({tag, "_idle"}, busy, 0);
    repeat (3) @(negedge clk);
    check({tag, "_wr_left"}, exp_w_q.size(), 0);
    check({tag, "_iss_left"}, exp_i_q.size(), 0);
  endtask

  task automatic check_drop(input string tag);
`ifdef SCHED_STATS_EN
    check({tag, "_drop"}, drop_count, exp_drop);
`else
    $display("%s: drops expected so far %0d", tag, exp_drop);
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit kill, latch;
    int m, k, n;
    apply_reset("reset");

    // Job {2,3,2}, A=1..6, B=7..12, ready high.
    clr_stats(); ready_mode = 0;
    make_job(2, 3, 2, 12, 0, 1); expect_issues();
    send_frame(); verdict(0, 2);
    wait_idle("t1", 200);
    check("t1_a_writes", n_awr, 6);
    check("t1_b_writes", n_bwr, 6);
    check("t1_issues", obs_i_q.size(), 12);
    if (obs_i_q.size() >= 3) begin
      check("t1_issue0", obs_i_q[0], {1'b1, 1'b0, 10'd0, 10'd0});
      check("t1_issue2", obs_i_q[2], {1'b0, 1'b1, 10'd2, 10'd4});
    end
    check("t1_run_cycles", done_cyc - first_v_cyc, 12);
    check("t1_dims", dims_at_run, {6'd2, 6'd3, 6'd2});
    check("t1_done_count", n_done, 1);

    // Same job with ready toggling.
    clr_stats(); ready_mode = 1;
    make_job(2, 3, 2, 12, 0, 1); expect_issues();
    send_frame(); verdict(0, 1);
    wait_idle("t2", 200);
    check("t2_issues", obs_i_q.size(), 12);
    check("t2_done_count", n_done, 1);

    // Bad headers: K=0, then M=33.
    clr_stats();
    frame_q = {8'd2, 8'd0, 8'd2, 8'd1, 8'd2, 8'd3, 8'd4};
    send_frame(); exp_drop++;
    wait_idle("t3a", 50);
    frame_q = {8'd33, 8'd1, 8'd1, 8'd5, 8'd5};
    send_frame(); exp_drop++;
    wait_idle("t3b", 50);
    check("t3_no_writes", n_awr + n_bwr, 0);
    check_drop("t3");

    // Short frame, then a 1x1x1 job.
    clr_stats(); ready_mode = 0;
    make_job(2, 3, 2, 4, 0, 0);
    send_frame(); exp_drop++;
    wait_idle("t4a", 50);
    check("t4_a_writes", n_awr, 4);
    make_job(1, 1, 1, 2, 0, 0); expect_issues();
    send_frame(); verdict(0, 0);
    wait_idle("t4b", 50);
    check("t4_issues", obs_i_q.size(), 1);
    if (obs_i_q.size() >= 1) check("t4_issue0", obs_i_q[0], {1'b1, 1'b1, 10'd0, 10'd0});
    check_drop("t4");

    // Killed verdict, then verdict timeout.
    clr_stats();
    make_job(2, 2, 2, 8, 0, 0);
    send_frame(); verdict(1, 3); exp_drop++;
    wait_idle("t5a", 50);
    check("t5_no_issues", obs_i_q.size(), 0);
    make_job(1, 2, 1, 4, 0, 0);
    send_frame();
    repeat (1000) @(negedge clk);
    check("t5_waiting", busy, 1);
    repeat (40) @(negedge clk);
    check("t5_timed_out", busy, 0);
    exp_drop++;
    check_drop("t5");

    // Verdict arriving with the last B element.
    clr_stats(); ready_mode = 2;
    make_job(2, 2, 3, 10, 2, 0); expect_issues();
    ck_at = 3 + 10 - 1; ck_at_kill = 1'b0;
    send_frame();
    wait_idle("t6", 200);
    check("t6_issues", obs_i_q.size(), 12);

    // New frame while running.
    clr_stats(); ready_mode = 1;
    make_job(3, 3, 3, 18, 0, 0); expect_issues();
    send_frame(); verdict(0, 1);
    for (int c = 0; c < 50 && !iss_valid; c++) @(negedge clk);
    check("t7_running", iss_valid, 1);
    frame_q = {8'd1, 8'd1, 8'd1, 8'd9, 8'd9};
    send_frame(); exp_drop++;
    wait_idle("t7", 300);
    check("t7_issues", obs_i_q.size(), 27);
    check("t7_done_count", n_done, 1);
    check_drop("t7");

    // Randomized jobs.
    for (int r = 0; r < 8; r++) begin
      clr_stats(); ready_mode = 2;
      m = $urandom_range(1, 4); k = $urandom_range(1, 4); n = $urandom_range(1, 4);
      kill = ($urandom_range(0, 3) == 0);
      latch = ($urandom_range(0, 3) == 0);
      make_job(m, k, n, m*k + k*n, $urandom_range(0, 2), 0);
      if (!kill) expect_issues(); else exp_drop++;
      if (latch) begin ck_at = 3 + m*k + k*n - 1; ck_at_kill = kill; end
      send_frame();
      if (!latch) verdict(kill, $urandom_range(0, 4));
      wait_idle("rnd", 400);
      check("rnd_done_count", n_done, kill ? 0 : 1);
    end
    check_drop("rnd");

    // Reset in the middle of a run.
    clr_stats(); ready_mode = 1;
    make_job(3, 3, 3, 18, 0, 0); expect_issues();
    send_frame(); verdict(0, 0);
    for (int c = 0; c < 100 && obs_i_q.size() < 5; c++) @(negedge clk);
    check("t9_started", 32'(obs_i_q.size() >= 5), 1);
    @(posedge clk); #1;
    apply_reset("midrun");
    clr_stats();
    repeat (10) @(negedge clk);
    check("t9_idle", busy, 0);
    check("t9_no_done", n_done, 0);
    check_drop("t9");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end

endmodule
